// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundles the fetch port, the load/store port and the shared memory port.
// The slave modport is the arbiter's view; the master modport is the requesters' and
// memory's view.
interface mem_arbiter_if;
  // Fetch (I) side
  logic        i_valid;
  logic [31:0] i_addr;
  logic [31:0] i_rdata;
  logic        i_ready;
  logic        i_error;
  // Load/store (D) side
  logic        d_valid;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_wstrb;
  logic [31:0] d_rdata;
  logic        d_ready;
  logic        d_error;
  // Shared memory port
  logic        mem_valid;
  logic        mem_instr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  modport slave (
    input  i_valid, i_addr, d_valid, d_addr, d_wdata, d_wstrb, mem_rdata, mem_ready,
    output i_rdata, i_ready, i_error, d_rdata, d_ready, d_error,
           mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb
  );

  modport master (
    output i_valid, i_addr, d_valid, d_addr, d_wdata, d_wstrb, mem_rdata, mem_ready,
    input  i_rdata, i_ready, i_error, d_rdata, d_ready, d_error,
           mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single memory port between instruction fetch (I) and load/store (D).
// Each side has a one-entry pending slot; one access is in flight at a time and a watchdog
// aborts accesses that wait TIMEOUT cycles for mem_ready.
// Optional macro MEM_ARB_RR_EN: round-robin between contested requests (default: D over I).
module mem_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input logic          clock,
  input logic          reset,
  mem_arbiter_if.slave bus
);

  localparam logic [15:0] TimeoutVal = 16'(TIMEOUT);

  typedef enum logic [1:0] {StIdle, StBusyI, StBusyD} state_e;

  state_e      r_state, w_state_next;
  logic        r_pend_i, r_pend_d;
  logic [31:0] r_i_addr, r_d_addr, r_d_wdata;
  logic [3:0]  r_d_wstrb;
  logic [15:0] r_cnt, w_cnt_next, w_cnt_inc;

  logic w_done, w_timeout, w_issue_i, w_issue_d, w_pick_d, w_busy_i, w_busy_d;

  logic        r_mem_valid, r_mem_instr;
  logic [31:0] r_mem_addr, r_mem_wdata;
  logic [3:0]  r_mem_wstrb;
  logic        r_i_ready, r_i_error, r_d_ready, r_d_error;
  logic [31:0] r_i_rdata, r_d_rdata;

  assign w_busy_i  = (r_state == StBusyI);
  assign w_busy_d  = (r_state == StBusyD);
  assign w_cnt_inc = r_cnt + 16'd1;

`ifdef MEM_ARB_RR_EN
  logic r_last_grant;  // 1: D won the last contested arbitration, 0: I did

  // When both slots are pending, favour the side that lost last time.
  assign w_pick_d = r_pend_d && (!r_pend_i || !r_last_grant);

  // Remember the winner of each contested arbitration.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_last_grant <= 1'b0;
    end else if (r_state == StIdle && r_pend_i && r_pend_d) begin
      r_last_grant <= w_pick_d;
    end
  end
`else
  assign w_pick_d = r_pend_d;
`endif

  // Next-state logic: arbitrate in idle, watch for completion or timeout while busy.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_done       = 1'b0;
    w_timeout    = 1'b0;
    w_issue_i    = 1'b0;
    w_issue_d    = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_pick_d) begin
          w_issue_d = 1'b1;
        end else if (r_pend_i) begin
          w_issue_i = 1'b1;
        end
      end
      StBusyI, StBusyD: begin
        w_cnt_next = w_cnt_inc;
        if (bus.mem_ready) begin
          w_done = 1'b1;
        end else if (w_cnt_inc == TimeoutVal) begin
          w_done    = 1'b1;
          w_timeout = 1'b1;
        end
        if (w_done) begin
          w_cnt_next   = '0;
          w_state_next = StIdle;
          // Hand the port straight to the other side if it is waiting.
          if (w_busy_i && r_pend_d) begin
            w_issue_d = 1'b1;
          end else if (w_busy_d && r_pend_i) begin
            w_issue_i = 1'b1;
          end
        end
      end
      default: w_state_next = StIdle;
    endcase
    if (w_issue_d) begin
      w_state_next = StBusyD;
    end else if (w_issue_i) begin
      w_state_next = StBusyI;
    end
  end

  // State register and watchdog counter.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= StIdle;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // Pending slots: capture only into an empty slot; clear when the owner's access ends.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_pend_i  <= 1'b0;
      r_pend_d  <= 1'b0;
      r_i_addr  <= '0;
      r_d_addr  <= '0;
      r_d_wdata <= '0;
      r_d_wstrb <= '0;
    end else begin
      if (bus.i_valid && !r_pend_i) begin
        r_pend_i <= 1'b1;
        r_i_addr <= bus.i_addr;
      end else if (w_done && w_busy_i) begin
        r_pend_i <= 1'b0;
      end
      if (bus.d_valid && !r_pend_d) begin
        r_pend_d  <= 1'b1;
        r_d_addr  <= bus.d_addr;
        r_d_wdata <= bus.d_wdata;
        r_d_wstrb <= bus.d_wstrb;
      end else if (w_done && w_busy_d) begin
        r_pend_d <= 1'b0;
      end
    end
  end

  // Memory request: one-cycle valid pulse, fields held for the whole access.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_mem_valid <= 1'b0;
      r_mem_instr <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_wstrb <= '0;
    end else begin
      r_mem_valid <= w_issue_i | w_issue_d;
      if (w_issue_d) begin
        r_mem_instr <= 1'b0;
        r_mem_addr  <= r_d_addr;
        r_mem_wdata <= r_d_wdata;
        r_mem_wstrb <= r_d_wstrb;
      end else if (w_issue_i) begin
        r_mem_instr <= 1'b1;
        r_mem_addr  <= r_i_addr;
        r_mem_wdata <= '0;
        r_mem_wstrb <= '0;
      end
    end
  end

  // Responses: one-cycle ready pulse to the owner; a timeout returns zero data with error.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_i_ready <= 1'b0;
      r_i_error <= 1'b0;
      r_i_rdata <= '0;
      r_d_ready <= 1'b0;
      r_d_error <= 1'b0;
      r_d_rdata <= '0;
    end else begin
      r_i_ready <= w_done & w_busy_i;
      r_i_error <= w_timeout & w_busy_i;
      r_d_ready <= w_done & w_busy_d;
      r_d_error <= w_timeout & w_busy_d;
      if (w_done && w_busy_i) begin
        r_i_rdata <= w_timeout ? 32'h0 : bus.mem_rdata;
      end
      if (w_done && w_busy_d) begin
        r_d_rdata <= w_timeout ? 32'h0 : bus.mem_rdata;
      end
    end
  end

  assign bus.mem_valid = r_mem_valid;
  assign bus.mem_instr = r_mem_instr;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.mem_wstrb = r_mem_wstrb;
  assign bus.i_rdata   = r_i_rdata;
  assign bus.i_ready   = r_i_ready;
  assign bus.i_error   = r_i_error;
  assign bus.d_rdata   = r_d_rdata;
  assign bus.d_ready   = r_d_ready;
  assign bus.d_error   = r_d_error;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios plus randomized traffic, checked every cycle against a
// transaction-level reference model of the arbiter. Built with TIMEOUT = 8.
module tb_mem_arbiter;

  localparam int unsigned Timeout = 8;

  logic clock;
  logic reset;

  mem_arbiter_if bus_if ();

  mem_arbiter #(
    .TIMEOUT(Timeout)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus_if)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        iv;
    logic [31:0] ia;
    logic        dv;
    logic [31:0] da;
    logic [31:0] dw;
    logic [3:0]  ds;
    logic        mr;
    logic [31:0] md;
  } stim_t;

  int unsigned n_checks;
  int unsigned n_fails;
  int unsigned n_i_rdy, n_d_rdy, n_mvalid;

  // Reference model: pending requests per side (0 = I, 1 = D), current owner, and the
  // outputs it expects in the coming cycle.
  int          m_owner;
  int unsigned m_busy;
  bit          m_pend  [2];
  logic [31:0] m_addr  [2];
  logic [31:0] m_wdata [2];
  logic [3:0]  m_wstrb [2];
  int          m_last;
  bit          e_mem_valid;
  logic        e_instr;
  logic [31:0] e_maddr, e_mwdata;
  logic [3:0]  e_mwstrb;
  bit          e_ready [2];
  bit          e_err   [2];
  logic [31:0] e_rdata [2];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic stim_t idle();
    stim_t s;
    s = '{iv: 1'b0, ia: 32'h0, dv: 1'b0, da: 32'h0, dw: 32'h0, ds: 4'h0, mr: 1'b0, md: 32'h0};
    return s;
  endfunction

  task automatic model_reset();
    m_owner     = -1;
    m_busy      = 0;
    m_last      = 0;
    e_mem_valid = 1'b0;
    e_instr     = 1'b0;
    e_maddr     = '0;
    e_mwdata    = '0;
    e_mwstrb    = '0;
    for (int k = 0; k < 2; k++) begin
      m_pend[k]  = 1'b0;
      m_addr[k]  = '0;
      m_wdata[k] = '0;
      m_wstrb[k] = '0;
      e_ready[k] = 1'b0;
      e_err[k]   = 1'b0;
      e_rdata[k] = '0;
    end
  endtask

  // Advance the model across one clock edge given this cycle's inputs.
  task automatic model_update(input stim_t s);
    bit old_pend [2];
    bit done;
    int nxt;
    old_pend    = m_pend;
    done        = 1'b0;
    nxt         = -1;
    e_mem_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      e_ready[k] = 1'b0;
      e_err[k]   = 1'b0;
    end
    if (s.iv && !m_pend[0]) begin
      m_pend[0]  = 1'b1;
      m_addr[0]  = s.ia;
      m_wdata[0] = '0;
      m_wstrb[0] = '0;
    end
    if (s.dv && !m_pend[1]) begin
      m_pend[1]  = 1'b1;
      m_addr[1]  = s.da;
      m_wdata[1] = s.dw;
      m_wstrb[1] = s.ds;
    end
    if (m_owner >= 0) begin
      m_busy++;
      if (s.mr) begin
        done             = 1'b1;
        e_ready[m_owner] = 1'b1;
        e_rdata[m_owner] = s.md;
      end else if (m_busy == Timeout) begin
        done             = 1'b1;
        e_ready[m_owner] = 1'b1;
        e_err[m_owner]   = 1'b1;
        e_rdata[m_owner] = '0;
      end
      if (done) begin
        m_pend[m_owner] = 1'b0;
        if (old_pend[1 - m_owner]) nxt = 1 - m_owner;
      end else begin
        nxt = m_owner;
      end
    end else if (old_pend[0] && old_pend[1]) begin
`ifdef MEM_ARB_RR_EN
      nxt    = 1 - m_last;
      m_last = nxt;
`else
      nxt = 1;
`endif
    end else if (old_pend[1]) begin
      nxt = 1;
    end else if (old_pend[0]) begin
      nxt = 0;
    end
    if (nxt >= 0 && (m_owner < 0 || done)) begin
      e_mem_valid = 1'b1;
      e_instr     = (nxt == 0);
      e_maddr     = m_addr[nxt];
      e_mwdata    = m_wdata[nxt];
      e_mwstrb    = m_wstrb[nxt];
      m_busy      = 0;
    end
    m_owner = nxt;
  endtask

  task automatic drive(input stim_t s);
    bus_if.i_valid   = s.iv;
    bus_if.i_addr    = s.ia;
    bus_if.d_valid   = s.dv;
    bus_if.d_addr    = s.da;
    bus_if.d_wdata   = s.dw;
    bus_if.d_wstrb   = s.ds;
    bus_if.mem_ready = s.mr;
    bus_if.mem_rdata = s.md;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, ".mem_valid"}, 32'(bus_if.mem_valid), 32'h0);
    check_eq({tag, ".mem_instr"}, 32'(bus_if.mem_instr), 32'h0);
    check_eq({tag, ".mem_addr"}, bus_if.mem_addr, 32'h0);
    check_eq({tag, ".mem_wdata"}, bus_if.mem_wdata, 32'h0);
    check_eq({tag, ".mem_wstrb"}, 32'(bus_if.mem_wstrb), 32'h0);
    check_eq({tag, ".i_ready"}, 32'(bus_if.i_ready), 32'h0);
    check_eq({tag, ".i_error"}, 32'(bus_if.i_error), 32'h0);
    check_eq({tag, ".i_rdata"}, bus_if.i_rdata, 32'h0);
    check_eq({tag, ".d_ready"}, 32'(bus_if.d_ready), 32'h0);
    check_eq({tag, ".d_error"}, 32'(bus_if.d_error), 32'h0);
    check_eq({tag, ".d_rdata"}, bus_if.d_rdata, 32'h0);
  endtask

  // One clock cycle: drive at posedge+1, compare at negedge, advance the model.
  task automatic step(input stim_t s);
    drive(s);
    @(negedge clock);
    check_eq("mem_valid", 32'(bus_if.mem_valid), 32'(e_mem_valid));
    if (m_owner >= 0) begin
      check_eq("mem_instr", 32'(bus_if.mem_instr), 32'(e_instr));
      check_eq("mem_addr", bus_if.mem_addr, e_maddr);
      check_eq("mem_wstrb", 32'(bus_if.mem_wstrb), 32'(e_mwstrb));
      if (!e_instr) check_eq("mem_wdata", bus_if.mem_wdata, e_mwdata);
    end
    check_eq("i_ready", 32'(bus_if.i_ready), 32'(e_ready[0]));
    check_eq("i_error", 32'(bus_if.i_error), 32'(e_err[0]));
    if (e_ready[0]) check_eq("i_rdata", bus_if.i_rdata, e_rdata[0]);
    check_eq("d_ready", 32'(bus_if.d_ready), 32'(e_ready[1]));
    check_eq("d_error", 32'(bus_if.d_error), 32'(e_err[1]));
    if (e_ready[1]) check_eq("d_rdata", bus_if.d_rdata, e_rdata[1]);
    if (bus_if.i_ready === 1'b1) n_i_rdy++;
    if (bus_if.d_ready === 1'b1) n_d_rdy++;
    if (bus_if.mem_valid === 1'b1) n_mvalid++;
    model_update(s);
    @(posedge clock);
    #1;
  endtask

  task automatic idles(input int n);
    for (int k = 0; k < n; k++) step(idle());
  endtask

  initial begin
    stim_t       s;
    int unsigned base;
    n_checks = 0;
    n_fails  = 0;
    n_i_rdy  = 0;
    n_d_rdy  = 0;
    n_mvalid = 0;
    drive(idle());
    model_reset();
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    check_all_zero("reset");
    reset = 1'b0;
    idles(2);

    // Single fetch, memory answers 3 cycles after mem_valid.
    base = n_i_rdy;
    s = idle(); s.iv = 1'b1; s.ia = 32'h0000_0100;
    step(s);
    idles(4);
    s = idle(); s.mr = 1'b1; s.md = 32'h0000_0013;
    step(s);
    idles(2);
    check_eq("fetch.ready_count", n_i_rdy - base, 32'd1);

    // Simultaneous I and D: D first, I back-to-back after D's mem_ready.
    s = idle();
    s.iv = 1'b1; s.ia = 32'h100;
    s.dv = 1'b1; s.da = 32'h2000; s.dw = 32'hDEAD_BEEF; s.ds = 4'hF;
    step(s);
    idles(2);
    s = idle(); s.mr = 1'b1; s.md = 32'h1111_2222;
    step(s);
    step(idle());
    s.md = 32'h3333_4444;
    step(s);
    idles(2);

    // Four contested pairs: grant order follows the arbitration policy.
    for (int p = 0; p < 4; p++) begin
      s = idle();
      s.iv = 1'b1; s.ia = 32'h400 + 32'(p * 4);
      s.dv = 1'b1; s.da = 32'h8000 + 32'(p * 4); s.dw = $urandom; s.ds = 4'(p);
      step(s);
      idles(2);
      s = idle(); s.mr = 1'b1; s.md = $urandom;
      step(s);
      step(idle());
      s.md = $urandom;
      step(s);
      idles(2);
    end

    // Timeout on D; a late mem_ready two cycles afterwards must be ignored.
    base = n_d_rdy;
    s = idle(); s.dv = 1'b1; s.da = 32'h3000;
    step(s);
    step(idle());
    idles(int'(Timeout) + 2);
    s = idle(); s.mr = 1'b1; s.md = 32'hBAD0_BAD0;
    step(s);
    idles(3);
    check_eq("timeout.ready_count", n_d_rdy - base, 32'd1);

    // Second fetch while the first is pending is dropped.
    base = n_i_rdy;
    s = idle(); s.iv = 1'b1; s.ia = 32'h100;
    step(s);
    s.ia = 32'h200;
    step(s);
    idles(2);
    s = idle(); s.mr = 1'b1; s.md = 32'h5555_6666;
    step(s);
    idles(4);
    check_eq("violation.ready_count", n_i_rdy - base, 32'd1);

    // Reset while D is in flight and I is pending.
    s = idle();
    s.iv = 1'b1; s.ia = 32'h100;
    s.dv = 1'b1; s.da = 32'h2000; s.dw = 32'h1234_5678; s.ds = 4'h3;
    step(s);
    idles(3);
    drive(idle());
    #2;
    reset = 1'b1;
    #1;
    check_all_zero("midreset");
    model_reset();
    @(posedge clock);
    #1;
    reset = 1'b0;
    base = n_mvalid;
    idles(8);
    check_eq("midreset.no_issue", n_mvalid - base, 32'd0);

    // Randomized traffic: busy memory first, then a slow one that often times out.
    for (int c = 0; c < 3000; c++) begin
      s    = idle();
      s.iv = ($urandom_range(0, 99) < 25);
      s.ia = $urandom;
      s.dv = ($urandom_range(0, 99) < 25);
      s.da = $urandom;
      s.dw = $urandom;
      s.ds = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
      s.mr = ($urandom_range(0, 99) < ((c < 2000) ? 30 : 8));
      s.md = $urandom;
      step(s);
    end
    idles(int'(Timeout) * 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
